// File: rtl/riscv_types.sv
// riscv_types: shared execute/writeback types for the FP result path
package riscv_types;
  typedef struct packed {
    logic [4:0] rd_addr;
    logic [2:0] rob_id;
    logic       rd_wb;
    logic       fp_dest;
  } exe_p_mux_bus_type;
  typedef struct packed {
    logic [31:0]       result;
    exe_p_mux_bus_type signals;
    logic [4:0]        fflags;
  } fp_wb_entry_t;
  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;
endpackage

// File: rtl/fp_wb_fifo.sv
// fp_wb_fifo: per-source circular result buffer with combinational head
module fp_wb_fifo
  import riscv_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fp_wb_entry_t             din,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output fp_wb_entry_t             head
);
  localparam int AW = $clog2(DEPTH);
  fp_wb_entry_t mem [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rptr];
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      count <= '0;
      rptr <= '0;
      wptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/fp_wb_arbiter.sv
// fp_wb_arbiter: round-robin serialiser of FP unit results onto one writeback port
module fp_wb_arbiter
  import riscv_types::*;
#(
  parameter int NUM_UNITS  = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush,
  input  logic [NUM_UNITS-1:0]         unit_valid,
  input  logic [31:0]                  unit_result [NUM_UNITS],
  input  exe_p_mux_bus_type            unit_signals [NUM_UNITS],
  input  logic [4:0]                   unit_fflags [NUM_UNITS],
  output logic [NUM_UNITS-1:0]         unit_en,
  output logic                         wb_valid,
  input  logic                         wb_ready,
  output logic [31:0]                  wb_result,
  output exe_p_mux_bus_type            wb_signals,
  output logic [4:0]                   wb_fflags,
  output logic [$clog2(NUM_UNITS)-1:0] wb_src
);
  localparam int SW = $clog2(NUM_UNITS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [NUM_UNITS-1:0] full, empty, push, pop, nz;
  logic [CW-1:0] count [NUM_UNITS];
  fp_wb_entry_t head [NUM_UNITS];
  fp_wb_entry_t din [NUM_UNITS];
  logic [SW-1:0] rr_ptr, lock_src, rr_sel, grant;
  logic lock;
  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_fifo
    assign unit_en[i] = !full[i];
    assign push[i] = unit_valid[i] && unit_en[i];
    assign pop[i] = wb_valid && wb_ready && grant == SW'(i);
    assign nz[i] = count[i] != '0;
    assign din[i] = '{result: unit_result[i], signals: unit_signals[i], fflags: unit_fflags[i]};
    fp_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .reset_n(reset_n),
      .flush(flush),
      .push(push[i]),
      .pop(pop[i]),
      .din(din[i]),
      .count(count[i]),
      .full(full[i]),
      .empty(empty[i]),
      .head(head[i])
    );
  end
  // descending scan so the nearest non-empty source above rr_ptr wins
  always_comb begin
    rr_sel = '0;
    for (int j = NUM_UNITS - 1; j >= 0; j--)
      if (!empty[(int'(rr_ptr) + j) % NUM_UNITS]) rr_sel = SW'((int'(rr_ptr) + j) % NUM_UNITS);
  end
  assign grant = lock ? lock_src : rr_sel;
  assign wb_valid = |nz;
  assign wb_result = wb_valid ? head[grant].result : '0;
  assign wb_signals = wb_valid ? head[grant].signals : '0;
  assign wb_fflags = wb_valid ? head[grant].fflags : '0;
  assign wb_src = wb_valid ? grant : '0;
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      rr_ptr <= '0;
      lock <= 1'b0;
      lock_src <= '0;
    end else if (wb_valid && wb_ready) begin
      rr_ptr <= grant == SW'(NUM_UNITS - 1) ? '0 : grant + SW'(1);
      lock <= 1'b0;
    end else if (wb_valid) begin
      lock <= 1'b1;
      lock_src <= grant;
    end
  end
endmodule

// File: tb/tb_fp_wb_arbiter.sv
// tb_fp_wb_arbiter: directed and random checks against a queue-based reference model
module tb_fp_wb_arbiter;
  import riscv_types::*;
  localparam int NU = 4;
  localparam int D = 2;
  localparam int SB = $bits(exe_p_mux_bus_type);
  logic clk = 0;
  logic reset_n = 0;
  logic flush = 0;
  logic wb_ready = 0;
  logic [NU-1:0] unit_valid;
  logic [31:0] unit_result [NU];
  exe_p_mux_bus_type unit_signals [NU];
  logic [4:0] unit_fflags [NU];
  logic [NU-1:0] unit_en;
  logic wb_valid;
  logic [31:0] wb_result;
  exe_p_mux_bus_type wb_signals;
  logic [4:0] wb_fflags;
  logic [1:0] wb_src;
  int n_chk = 0;
  int n_pass = 0;
  fp_wb_entry_t q [NU][$];
  int m_rr = 0;
  bit m_lock = 0;
  int m_lsrc = 0;
  bit pend [NU];
  fp_wb_entry_t pent [NU];

  always #5 clk = ~clk;

  fp_wb_arbiter #(.NUM_UNITS(NU), .FIFO_DEPTH(D)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .flush(flush),
    .unit_valid(unit_valid),
    .unit_result(unit_result),
    .unit_signals(unit_signals),
    .unit_fflags(unit_fflags),
    .unit_en(unit_en),
    .wb_valid(wb_valid),
    .wb_ready(wb_ready),
    .wb_result(wb_result),
    .wb_signals(wb_signals),
    .wb_fflags(wb_fflags),
    .wb_src(wb_src)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic int m_grant();
    if (m_lock) return m_lsrc;
    for (int j = 0; j < NU; j++) if (q[(m_rr + j) % NU].size() != 0) return (m_rr + j) % NU;
    return 0;
  endfunction

  function automatic bit m_valid();
    for (int i = 0; i < NU; i++) if (q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NU-1:0] m_en();
    logic [NU-1:0] e;
    for (int i = 0; i < NU; i++) e[i] = q[i].size() != D;
    return e;
  endfunction

  task automatic drive();
    for (int i = 0; i < NU; i++) begin
      unit_valid[i] = pend[i];
      unit_result[i] = pent[i].result;
      unit_signals[i] = pent[i].signals;
      unit_fflags[i] = pent[i].fflags;
    end
  endtask

  task automatic set_pend(input int i, input logic [31:0] r, input logic [4:0] f);
    logic [SB-1:0] sb;
    sb = SB'($urandom);
    pend[i] = 1'b1;
    pent[i].result = r;
    pent[i].fflags = f;
    pent[i].signals = sb;
  endtask

  task automatic cyc();
    logic [NU-1:0] en;
    bit v;
    int g;
    drive();
    @(negedge clk);
    en = m_en();
    v = m_valid();
    g = m_grant();
    check("wb_valid", 32'(wb_valid), 32'(v));
    check("wb_src", 32'(wb_src), v ? 32'(g) : 32'd0);
    check("unit_en", 32'(unit_en), 32'(en));
    if (v) begin
      check("wb_result", wb_result, q[g][0].result);
      check("wb_fflags", 32'(wb_fflags), 32'(q[g][0].fflags));
      check("wb_signals", 32'(wb_signals), 32'(q[g][0].signals));
    end else begin
      check("wb_result_zero", wb_result, 32'd0);
      check("wb_payload_zero", 32'({wb_signals, wb_fflags}), 32'd0);
    end
    @(posedge clk);
    if (!reset_n || flush) begin
      for (int i = 0; i < NU; i++) q[i].delete();
      m_rr = 0;
      m_lock = 0;
    end else begin
      if (v && wb_ready) begin
        void'(q[g].pop_front());
        m_rr = (g + 1) % NU;
        m_lock = 0;
      end else if (v) begin
        m_lock = 1;
        m_lsrc = g;
      end
      for (int i = 0; i < NU; i++) if (pend[i] && en[i]) q[i].push_back(pent[i]);
    end
    for (int i = 0; i < NU; i++) if (en[i]) pend[i] = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset_n = 0;
    flush = 0;
    wb_ready = 0;
    for (int i = 0; i < NU; i++) pend[i] = 1'b0;
    cyc();
    reset_n = 1;
  endtask

  initial begin
    for (int i = 0; i < NU; i++) begin
      pend[i] = 1'b0;
      pent[i] = '0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    check("rst_valid", 32'(wb_valid), 32'd0);
    check("rst_en", 32'(unit_en), 32'hf);
    check("rst_result", wb_result, 32'd0);
    wb_ready = 1;
    set_pend(0, 32'h7fc00000, 5'b10000);
    cyc();
    check("t1_valid", 32'(wb_valid), 32'd1);
    check("t1_src", 32'(wb_src), 32'd0);
    check("t1_result", wb_result, 32'h7fc00000);
    check("t1_fflags", 32'(wb_fflags), 32'h10);
    cyc();
    check("t1_idle_valid", 32'(wb_valid), 32'd0);
    check("t1_idle_payload", wb_result | 32'({wb_signals, wb_fflags, wb_src}), 32'd0);
    do_reset();
    wb_ready = 1;
    for (int i = 0; i < NU; i++) set_pend(i, 32'(i + 1), 5'(i));
    cyc();
    for (int k = 0; k < NU; k++) begin
      check("t2_src", 32'(wb_src), 32'(k));
      check("t2_result", wb_result, 32'(k + 1));
      check("t2_en", 32'(unit_en), 32'hf);
      cyc();
    end
    check("t2_done", 32'(wb_valid), 32'd0);
    do_reset();
    set_pend(2, 32'ha1, 5'd1);
    cyc();
    set_pend(2, 32'ha2, 5'd2);
    cyc();
    set_pend(2, 32'ha3, 5'd3);
    check("t3_en_low", 32'(unit_en), 32'hb);
    cyc();
    cyc();
    check("t3_en_held", 32'(unit_en), 32'hb);
    check("t3_first", wb_result, 32'ha1);
    wb_ready = 1;
    cyc();
    check("t3_second", wb_result, 32'ha2);
    check("t3_en_back", 32'(unit_en), 32'hf);
    cyc();
    check("t3_third", wb_result, 32'ha3);
    cyc();
    check("t3_done", 32'(wb_valid), 32'd0);
    do_reset();
    set_pend(3, 32'hb3, 5'd7);
    cyc();
    set_pend(0, 32'hb0, 5'd8);
    cyc();
    check("t4_lock_src", 32'(wb_src), 32'd3);
    check("t4_lock_res", wb_result, 32'hb3);
    cyc();
    check("t4_lock_src2", 32'(wb_src), 32'd3);
    check("t4_lock_res2", wb_result, 32'hb3);
    wb_ready = 1;
    cyc();
    check("t4_next_src", 32'(wb_src), 32'd0);
    check("t4_next_res", wb_result, 32'hb0);
    cyc();
    check("t4_done", 32'(wb_valid), 32'd0);
    do_reset();
    wb_ready = 1;
    for (int n = 0; n < 8; n++) begin
      if (!pend[0]) set_pend(0, 32'hc000 + 32'(n), 5'd0);
      if (!pend[1]) set_pend(1, 32'hc100 + 32'(n), 5'd0);
      cyc();
      check("t5_alt", 32'(wb_src), 32'(n % 2));
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    repeat (8) cyc();
    do_reset();
    set_pend(0, 32'hd0, 5'd0);
    set_pend(1, 32'hd1, 5'd0);
    cyc();
    check("t6_buffered", 32'(wb_valid), 32'd1);
    flush = 1;
    set_pend(2, 32'hd2, 5'd0);
    cyc();
    flush = 0;
    check("t6_flush_valid", 32'(wb_valid), 32'd0);
    check("t6_flush_en", 32'(unit_en), 32'hf);
    cyc();
    check("t6_discarded", 32'(wb_valid), 32'd0);
    do_reset();
    set_pend(0, 32'he0, 5'd0);
    set_pend(2, 32'he2, 5'd0);
    cyc();
    set_pend(0, 32'he1, 5'd0);
    cyc();
    check("t7_full", 32'(unit_en), 32'he);
    reset_n = 0;
    cyc();
    reset_n = 1;
    check("t7_valid", 32'(wb_valid), 32'd0);
    check("t7_en", 32'(unit_en), 32'hf);
    check("t7_result", wb_result, 32'd0);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NU; i++)
        if (!pend[i] && $urandom_range(0, 2) == 0) set_pend(i, $urandom, 5'($urandom));
      wb_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 63) == 0;
      reset_n = $urandom_range(0, 255) != 0;
      cyc();
    end
    flush = 0;
    reset_n = 1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fp_wb_arbiter.md
# fp_wb_arbiter

Collects completed results from the floating-point execution units (misc FPU, add/sub, multiply, divide/sqrt) and serialises them onto the single FP writeback port, one result per cycle. Sits directly downstream of each unit's `p_last` / `o_pipelined_signals` / `result` outputs. Drives each unit's `en` input so that no completed result is ever lost.

## Interface

Parameters:
- `NUM_UNITS`, 4: number of FP result sources; index 0 is the misc FPU.
- `FIFO_DEPTH`, 2: entries per source buffer; power of two, ≥ 2.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: reset, synchronous and active-low.
- `flush` in 1: synchronous pipeline flush; discards all buffered results.
- `unit_valid` in [NUM_UNITS]: per-unit `p_last`.
- `unit_result` in [NUM_UNITS][32]: per-unit result.
- `unit_signals` in [NUM_UNITS] `exe_p_mux_bus_type`: per-unit pipelined control bus.
- `unit_fflags` in [NUM_UNITS][5]: per-unit exception flags {NV,DZ,OF,UF,NX}.
- `unit_en` out [NUM_UNITS]: enable to each unit's `en`.
- `wb_valid` out 1: writeback entry present.
- `wb_ready` in 1: writeback stage accepts this cycle.
- `wb_result` out 32: selected result.
- `wb_signals` out `exe_p_mux_bus_type`: selected control bus.
- `wb_fflags` out 5: selected flags.
- `wb_src` out $clog2(NUM_UNITS): index of the granted unit.

## Operation

- One FIFO per source. Entry = {result, signals, fflags}.
- `unit_en[i] = (count[i] != FIFO_DEPTH)`. This is a function of registered state only; there is no combinational path from `wb_ready`.
- Push: `push[i] = unit_valid[i] && unit_en[i]`.
  - A unit whose `en` is low holds its outputs. Its result is captured in the first cycle `unit_en[i]` rises.
- Pop: `wb_valid && wb_ready` pops the granted FIFO's head.
- Same FIFO, same cycle, push and pop: both occur and `count` is unchanged.
- Arbitration is round-robin over non-empty FIFOs, searching from `rr_ptr` upward with wrap-around.
  - On a pop from source k, `rr_ptr <= (k+1) mod NUM_UNITS`.
  - While `wb_valid && !wb_ready`, the grant is locked. `wb_src` and all payload outputs stay stable until accepted, even if a higher-priority FIFO fills.
- `wb_valid = |(count != 0)`. When `wb_valid` is 0, `wb_result`, `wb_signals`, `wb_fflags` and `wb_src` are driven to 0.
- Flush:
  - All counts and pointers are cleared, `rr_ptr <= 0`, and the grant lock is released.
  - Pushes and pops in the flush cycle are discarded; flush has priority.
  - `unit_en` is computed from pre-flush counts in that cycle.
- Reset (`reset_n` low at a clock edge):
  - All counts 0, pointers 0, `rr_ptr` 0, lock cleared.
  - Outputs after reset: `wb_valid`=0, payload outputs 0, `unit_en` all 1.
  - Reset asserted mid-operation drops all buffered results.

## Timing

- Latency from capture to `wb_valid`: 1 cycle. A `unit_valid` push at edge N makes the entry visible at the head after edge N, with `wb_valid`=1 in cycle N+1.
- Output is read from the FIFO head, so payload is combinational from registered storage.
- Throughput: one result per cycle with `wb_ready` held high, regardless of the number of simultaneous completions.
- Full FIFO: `unit_en[i]` goes low in the cycle after the push that filled it. It goes high in the cycle after the first pop from that FIFO.
- With all `NUM_UNITS` valid in one cycle, all are captured that cycle, provided none was full.

## Structure

- Shared package `riscv_types` gains:
  - `fp_wb_entry_t` (struct: `result[31:0]`, `signals` `exe_p_mux_bus_type`, `fflags[4:0]`).
  - fflags bit-position constants `FFLAG_NV`..`FFLAG_NX`.
- Sub-module `fp_wb_fifo`:
  - Parameterised on depth; payload is `fp_wb_entry_t`.
  - Ports: push/pop/flush, `count`, `full`, `empty`, `head`.
  - Implemented as a pointer-based circular buffer with wrap at `FIFO_DEPTH`.
  - Instantiated `NUM_UNITS` times.
- Top level contains the round-robin arbiter, grant lock and output mux.

## Test plan

- Reset, then single push: `unit_valid[0]`=1 with `result`=32'h7fc00000, `fflags`=5'b10000, `wb_ready`=1.
  - Required: next cycle `wb_valid`=1, `wb_src`=0, `wb_result`=32'h7fc00000, `wb_fflags`=5'b10000.
  - The cycle after that: `wb_valid`=0 with all payload outputs 0.
- Simultaneous completion: all four `unit_valid` high in one cycle, results 1,2,3,4, `rr_ptr`=0, `wb_ready`=1.
  - Required: outputs 1,2,3,4 on `wb_src` 0,1,2,3 in four consecutive cycles.
  - `unit_en` stays 1 throughout.
- Backpressure:
  - Stimulus: `wb_ready`=0; unit 2 pushes 3 results on consecutive cycles.
  - Required: `unit_en[2]` drops after the 2nd push and the unit holds result #3.
  - Then `wb_ready`=1: the order delivered is #1, #2, #3 with none lost or duplicated.
- Grant lock:
  - Stimulus: unit 3 valid while `wb_ready`=0; unit 0 becomes valid the next cycle.
  - Required: `wb_src` stays 3 with payload stable until accepted; unit 0's entry follows.
- Round-robin fairness: units 0 and 1 continuously valid, `wb_ready`=1.
  - Required: `wb_src` alternates 0,1,0,1.
- Flush and reset mid-operation:
  - Stimulus: `flush` with 2 entries buffered and a push in the same cycle.
  - Required: next cycle `wb_valid`=0 and all counts are 0.
  - Stimulus: synchronous `reset_n` low with entries buffered.
  - Required: the same result, plus `unit_en` all 1.
